// File: rtl/quant_pkg.sv
// Shared types and constants for the multi-channel INT8 quantizer.
package quant_pkg;

  localparam int ACC_W       = 32;
  localparam int OUT_W       = 8;
  localparam int LEAKY_SHIFT = 3;
  localparam int Q_MAX       = 127;
  localparam int Q_MIN       = -128;

  // Per-channel requantization parameters.
  typedef struct packed {
    logic [31:0] m;
    logic [4:0]  n;
    logic        relu;
  } quant_param_t;

  // Unity gain: M = 1.0 in Q16, shifted back down by 16.
  localparam quant_param_t QP_IDENTITY = '{m: 32'h0001_0000, n: 5'd16, relu: 1'b0};

  // Clamp a full-width scaled value into the signed INT8 range.
  function automatic logic [OUT_W-1:0] sat8(input logic signed [63:0] s);
    if (s > 64'(Q_MAX))
      return OUT_W'(Q_MAX);
    else if (s < 64'(Q_MIN))
      return OUT_W'(Q_MIN);
    else
      return s[OUT_W-1:0];
  endfunction

endpackage

// File: rtl/quant_lane.sv
// One lane of the quantizer: leaky-ReLU, multiply, shift, saturate in four
// registered stages, all advancing together on adv.
// Optional build macro QUANT_ROUND_EN: round half toward +inf in the shift stage
// instead of a plain floor shift.
module quant_lane
  import quant_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    adv,
  input  logic signed [ACC_W-1:0] d,
  input  quant_param_t            param,
  output logic [OUT_W-1:0]        q
);

  logic signed [ACC_W-1:0] d1;
  quant_param_t            p1;
  logic signed [63:0]      prod2;
  logic [4:0]              n2;
  logic signed [63:0]      s3;

  logic signed [ACC_W-1:0] leaky;
  logic signed [63:0]      prod;
  logic signed [63:0]      shifted;

  // Combinational arithmetic between the stage registers.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    leaky   = d1;
    prod    = '0;
    shifted = '0;
    if (p1.relu && d1 < 0)
      leaky = d1 >>> LEAKY_SHIFT;
    // M is unsigned, so it is zero-extended before the signed multiply.
    prod = $signed({{(64-ACC_W){leaky[ACC_W-1]}}, leaky}) * $signed({32'd0, p1.m});
`ifdef QUANT_ROUND_EN
    shifted = (prod2 + ((n2 != 5'd0) ? (64'sd1 <<< (n2 - 5'd1)) : 64'sd0)) >>> n2;
`else
    shifted = prod2 >>> n2;
`endif
  end

  // Stage registers: capture, product, shifted value, saturated output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d1    <= '0;
      p1    <= QP_IDENTITY;
      prod2 <= '0;
      n2    <= '0;
      s3    <= '0;
      q     <= '0;
    end else if (adv) begin
      // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
      d1    <= d;
      p1    <= param;
      prod2 <= prod;
      n2    <= p1.n;
      s3    <= shifted;
      q     <= sat8(s3);
    end
  end

endmodule

// File: rtl/quantizer_mc.sv
// Multi-lane quantizer top: per-channel parameter table (one bank per lane),
// group counter, valid chain and valid/ready handshake around PAR quant_lane
// instances. Optional build macro QUANT_ROUND_EN selects rounding in the lanes.
module quantizer_mc
  import quant_pkg::*;
#(
  parameter int PAR    = 4,
  parameter int NUM_CH = 16,
  parameter int GW     = (NUM_CH / PAR > 1) ? $clog2(NUM_CH / PAR) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cfg_we,
  input  logic [$clog2(NUM_CH)-1:0] cfg_addr,
  input  logic [31:0]               cfg_m,
  input  logic [4:0]                cfg_n,
  input  logic                      cfg_relu,
  input  logic [GW-1:0]             num_grp,
  input  logic                      grp_clear,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [PAR*ACC_W-1:0]      in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [PAR*OUT_W-1:0]      out_data,
  output logic [GW-1:0]             out_grp
);

  localparam int NR = NUM_CH / PAR;

  quant_param_t tbl [NR][PAR];
  quant_param_t lane_param [PAR];

  logic          adv;
  logic          accept;
  logic          wr_en;
  logic [GW-1:0] grp_cnt;
  logic [GW-1:0] grp_use;
  logic [3:0]    v;
  logic [GW-1:0] g [4];

  // Handshake, effective group for this beat, and per-lane table read.
  always_comb begin
    adv     = ~v[3] | out_ready;
    accept  = in_valid & adv;
    wr_en   = cfg_we && (32'(cfg_addr) < 32'(NUM_CH));
    grp_use = grp_clear ? '0 : grp_cnt;
    for (int i = 0; i < PAR; i++)
      lane_param[i] = tbl[grp_use][i];
  end

  assign in_ready  = adv;
  assign out_valid = v[3];
  assign out_grp   = g[3];

  // Parameter table: channel addr lives in bank addr%PAR, row addr/PAR.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the table is deliberately reset so every channel starts at unity gain; this forces flops, not RAM.
      for (int r = 0; r < NR; r++)
        for (int b = 0; b < PAR; b++)
          tbl[r][b] <= QP_IDENTITY;
    end else if (wr_en) begin
      for (int r = 0; r < NR; r++)
        for (int b = 0; b < PAR; b++)
          if (int'(cfg_addr) == r * PAR + b)
            tbl[r][b] <= '{m: cfg_m, n: cfg_n, relu: cfg_relu};
    end
  end

  // Group counter: advances per accepted beat, wraps at num_grp, restarts on grp_clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      grp_cnt <= '0;
    else if (accept)
      grp_cnt <= (grp_use == num_grp) ? '0 : GW'(grp_use + 1'b1);
    else if (grp_clear)
      grp_cnt <= '0;
  end

  // Valid and group-index chain, moving in lockstep with the lane stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v <= '0;
      for (int k = 0; k < 4; k++)
        g[k] <= '0;
    end else if (adv) begin
      v <= {v[2:0], in_valid};
      g[0] <= grp_use;
      for (int k = 1; k < 4; k++)
        g[k] <= g[k-1];
    end
  end

  for (genvar i = 0; i < PAR; i++) begin : g_lane
    quant_lane u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .adv   (adv),
      .d     (in_data[ACC_W*i +: ACC_W]),
      .param (lane_param[i]),
      .q     (out_data[OUT_W*i +: OUT_W])
    );
  end

endmodule

// File: tb/tb_quantizer_mc.sv
// Self-checking bench for quantizer_mc: directed steps plus a randomized phase,
// checked against a cycle-level behavioural model of the pipeline.
module tb_quantizer_mc;

  localparam int PAR    = 4;
  localparam int NUM_CH = 16;
  localparam int GW     = 2;
`ifdef QUANT_ROUND_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                cfg_we = 1'b0;
  logic [3:0]          cfg_addr = '0;
  logic [31:0]         cfg_m = '0;
  logic [4:0]          cfg_n = '0;
  logic                cfg_relu = 1'b0;
  logic [GW-1:0]       num_grp = '0;
  logic                grp_clear = 1'b0;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic [PAR*32-1:0]   in_data = '0;
  logic                out_valid;
  logic                out_ready = 1'b1;
  logic [PAR*8-1:0]    out_data;
  logic [GW-1:0]       out_grp;

  quantizer_mc #(.PAR(PAR), .NUM_CH(NUM_CH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_m     (cfg_m),
    .cfg_n     (cfg_n),
    .cfg_relu  (cfg_relu),
    .num_grp   (num_grp),
    .grp_clear (grp_clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_grp   (out_grp)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct {
    bit               v;
    logic [PAR*8-1:0] q;
    logic [GW-1:0]    g;
  } beat_t;

  beat_t       pipe[$];
  logic [31:0] tm_m [NUM_CH];
  int          tm_n [NUM_CH];
  bit          tm_r [NUM_CH];
  int          gcnt;
  int          errors = 0;
  int          checks = 0;
  int          n_hs   = 0;

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic longint floor_div(longint a, longint b);
    longint q;
    q = a / b;
    if ((a % b) != 0 && a < 0) q = q - 1;
    return q;
  endfunction

  // Quantize one accumulator value from the arithmetic definition.
  function automatic logic [7:0] ref_q(longint d, logic [31:0] m, int n, bit relu);
    longint l, p, s, div;
    l = d;
    if (relu && d < 0) l = floor_div(d, 8);
    p = l * longint'({32'd0, m});
    div = longint'(1) << n;
    if (RND && n > 0) p = p + div / 2;
    s = floor_div(p, div);
    if (s > 127) s = 127;
    if (s < -128) s = -128;
    return s[7:0];
  endfunction

  function automatic logic [7:0] lane_out(int i);
    return out_data[8*i +: 8];
  endfunction

  task automatic model_reset();
    beat_t e;
    e.v = 1'b0; e.q = '0; e.g = '0;
    pipe.delete();
    for (int k = 0; k < 4; k++) pipe.push_back(e);
    for (int c = 0; c < NUM_CH; c++) begin
      tm_m[c] = 32'h0001_0000; tm_n[c] = 16; tm_r[c] = 1'b0;
    end
    gcnt = 0;
  endtask

  // One clock cycle: inputs are already driven; checks in_ready before the
  // edge and the outputs on the following falling edge.
  task automatic tick();
    bit    adv, acc;
    int    g_use;
    beat_t nb;
    #1;
    adv = !pipe[3].v || out_ready;
    check("in_ready", {63'd0, in_ready}, {63'd0, adv});
    if (out_valid && out_ready) n_hs++;
    acc   = in_valid && adv;
    g_use = grp_clear ? 0 : gcnt;
    nb.v = acc; nb.q = '0; nb.g = GW'(g_use);
    if (acc)
      for (int i = 0; i < PAR; i++) begin
        int d;
        int c;
        d = $signed(in_data[32*i +: 32]);
        c = g_use * PAR + i;
        nb.q[8*i +: 8] = ref_q(longint'(d), tm_m[c], tm_n[c], tm_r[c]);
      end
    @(posedge clk);
    if (adv) begin
      void'(pipe.pop_back());
      pipe.push_front(nb);
    end
    if (acc) gcnt = (g_use == int'(num_grp)) ? 0 : g_use + 1;
    else if (grp_clear) gcnt = 0;
    if (cfg_we && int'(cfg_addr) < NUM_CH) begin
      tm_m[cfg_addr] = cfg_m; tm_n[cfg_addr] = int'(cfg_n); tm_r[cfg_addr] = cfg_relu;
    end
    @(negedge clk);
    check("out_valid", {63'd0, out_valid}, {63'd0, pipe[3].v});
    if (pipe[3].v) begin
      check("out_data", 64'(out_data), 64'(pipe[3].q));
      check("out_grp", 64'(out_grp), 64'(pipe[3].g));
    end
  endtask

  task automatic set_lanes(int a, int b, int c, int e);
    in_data[31:0]   = 32'(a);
    in_data[63:32]  = 32'(b);
    in_data[95:64]  = 32'(c);
    in_data[127:96] = 32'(e);
  endtask

  task automatic cfg_wr(int ch, logic [31:0] m, int n, bit r);
    cfg_we = 1'b1; cfg_addr = 4'(ch); cfg_m = m; cfg_n = 5'(n); cfg_relu = r;
    tick();
    cfg_we = 1'b0;
  endtask

  // Single beat into an empty pipeline; returns when it is on the output.
  task automatic send_one(int a, int b, int c, int e);
    set_lanes(a, b, c, e);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    check("latency_early", {63'd0, out_valid}, 64'd0);
    tick();
    check("latency_4", {63'd0, out_valid}, 64'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int hs0, sent;
    model_reset();

    // Reset state
    #12;
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_out_data", 64'(out_data), 64'd0);
    check("rst_out_grp", 64'(out_grp), 64'd0);
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: identity table, saturation at both ends
    send_one(50, -50, 200, -300);
    check("t1_lane0", 64'(lane_out(0)), 64'h32);
    check("t1_lane1", 64'(lane_out(1)), 64'hCE);
    check("t1_lane2", 64'(lane_out(2)), 64'h7F);
    check("t1_lane3", 64'(lane_out(3)), 64'h80);

    // 2: leaky ReLU and scaled channels
    cfg_wr(1, 32'h0001_0000, 16, 1'b1);
    cfg_wr(2, 32'h0000_8000, 16, 1'b0);
    cfg_wr(3, 32'h0000_0001, 16, 1'b0);
    send_one(0, -80, 100, 100);
    check("t2_leaky80", 64'(lane_out(1)), 64'hF6);
    check("t2_half", 64'(lane_out(2)), 64'h32);
    check("t2_tiny", 64'(lane_out(3)), 64'h00);
    send_one(0, -8, 0, 0);
    check("t2_leaky8", 64'(lane_out(1)), 64'hFF);

    // 3: two groups, then grp_clear on the second beat
    for (int c = 4; c < 8; c++) cfg_wr(c, 32'h0002_0000, 16, 1'b0);
    num_grp = 2'd1;
    set_lanes(10, 10, 10, 10);
    in_valid = 1'b1;
    repeat (3) tick();
    in_valid = 1'b0;
    repeat (4) tick();
    grp_clear = 1'b1;
    tick();
    in_valid = 1'b1;
    grp_clear = 1'b0;
    tick();
    grp_clear = 1'b1;
    tick();
    grp_clear = 1'b0;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    num_grp = 2'd0;
    grp_clear = 1'b1;
    tick();
    grp_clear = 1'b0;

    // 4: 8-beat stream with out_ready low in cycles 6..9
    hs0 = n_hs;
    sent = 0;
    for (int c = 1; c <= 30; c++) begin
      in_valid  = (sent < 8);
      out_ready = !(c >= 6 && c <= 9);
      set_lanes(c * 7, -c * 13, c * 40, -c * 50);
      if (in_valid && in_ready) sent++;
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("t4_outputs", 64'(n_hs - hs0), 64'd8);

    // 5: cfg write coinciding with acceptance uses the old value
    set_lanes(20, 0, 0, 0);
    in_valid = 1'b1;
    cfg_we = 1'b1; cfg_addr = 4'd0; cfg_m = 32'h0002_0000; cfg_n = 5'd16; cfg_relu = 1'b0;
    tick();
    cfg_we = 1'b0;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    check("t5_old_m", 64'(lane_out(0)), 64'd20);
    tick();
    check("t5_new_m", 64'(lane_out(0)), 64'd40);
    //    reset mid-stream
    in_valid = 1'b1;
    repeat (5) begin
      set_lanes($urandom_range(0, 200) - 100, 5, 6, 7);
      tick();
    end
    #2 rst_n = 1'b0;
    #1;
    check("t5_rst_valid", {63'd0, out_valid}, 64'd0);
    check("t5_rst_data", 64'(out_data), 64'd0);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    send_one(10, 0, 0, 0);
    check("t5_identity", 64'(lane_out(0)), 64'd10);

    // 6: extremes and rounding
    cfg_wr(0, 32'hFFFF_FFFF, 31, 1'b0);
    cfg_wr(1, 32'h0000_03CA, 16, 1'b1);
    cfg_wr(2, 32'h0000_8000, 16, 1'b0);
    send_one(100, -1000, 3, 0);
    check("t6_big_m", 64'(lane_out(0)), 64'h7F);
    check("t6_leaky", 64'(lane_out(1)), 64'hFE);
    check("t6_round", 64'(lane_out(2)), RND ? 64'd2 : 64'd1);

    // Randomized traffic: table writes, stalls, bubbles, group restarts
    num_grp = 2'd3;
    grp_clear = 1'b1;
    tick();
    grp_clear = 1'b0;
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      grp_clear = ($urandom_range(0, 15) == 0);
      for (int i = 0; i < PAR; i++)
        in_data[32*i +: 32] = $urandom_range(0, 1) ? $urandom()
                                                    : 32'($urandom_range(0, 4000)) - 32'd2000;
      cfg_we   = ($urandom_range(0, 5) == 0);
      cfg_addr = 4'($urandom_range(0, NUM_CH - 1));
      cfg_m    = $urandom_range(0, 1) ? $urandom() : 32'($urandom_range(0, 32'h0003_0000));
      cfg_n    = 5'($urandom_range(0, 31));
      cfg_relu = 1'($urandom_range(0, 1));
      tick();
    end
    in_valid = 1'b0; cfg_we = 1'b0; grp_clear = 1'b0; out_ready = 1'b1;
    repeat (6) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
